// File: rtl/lbox_layer_seq_pkg.sv
// Shared constants, FSM state type and bit-order helpers for the Clyde-128 L-box layer.
package lbox_layer_seq_pkg;

  localparam int STATE_W = 128;
  localparam int WORD_W  = 32;

  // Forward L-box rotation amounts (right rotations)
  localparam int unsigned LB_R0 = 12;
  localparam int unsigned LB_R1 = 3;
  localparam int unsigned LB_R2 = 17;
  localparam int unsigned LB_R3 = 31;
  localparam int unsigned LB_R4 = 26;
  localparam int unsigned LB_R5 = 25;
  localparam int unsigned LB_R6 = 15;

  // Inverse L-box rotation amounts (right rotations)
  localparam int unsigned LI_R0 = 25;
  localparam int unsigned LI_R1 = 31;
  localparam int unsigned LI_R2 = 20;
  localparam int unsigned LI_R3 = 26;
  localparam int unsigned LI_R4 = 17;
  localparam int unsigned LI_R5 = 16;

  localparam logic PASS_LAST = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int unsigned n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  // Full 32-bit reverse followed by a byte swap leaves every byte in place, bit-reversed.
  function automatic logic [WORD_W-1:0] byte_bitrev(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) r[i] = w[WORD_W-1-i];
    return {r[7:0], r[15:8], r[23:16], r[31:24]};
  endfunction

  function automatic logic [STATE_W-1:0] state_conv(input logic [STATE_W-1:0] s);
    return {byte_bitrev(s[127:96]), byte_bitrev(s[95:64]),
            byte_bitrev(s[63:32]), byte_bitrev(s[31:0])};
  endfunction

endpackage

// File: rtl/lbox_layer_seq_core.sv
// Combinational Clyde-128 L-box on one word pair; i_mode selects forward (0) or inverse (1).
module lbox_layer_seq_core
  import lbox_layer_seq_pkg::*;
(
  input  logic [WORD_W-1:0] i_x,
  input  logic [WORD_W-1:0] i_y,
  input  logic              i_mode,
  output logic [WORD_W-1:0] o_a,
  output logic [WORD_W-1:0] o_b
);

  logic [WORD_W-1:0] w_fa0, w_fb0, w_fa1, w_fb1, w_fa2, w_fb2, w_fc, w_fd, w_fa, w_fb;
  logic [WORD_W-1:0] w_ia0, w_ib0, w_ic0, w_id0, w_ia1, w_ib1, w_ic1, w_id1, w_ia2, w_ib2;

  assign w_fa0 = i_x ^ rotr(i_x, LB_R0);
  assign w_fb0 = i_y ^ rotr(i_y, LB_R0);
  assign w_fa1 = w_fa0 ^ rotr(w_fa0, LB_R1);
  assign w_fb1 = w_fb0 ^ rotr(w_fb0, LB_R1);
  assign w_fa2 = w_fa1 ^ rotr(i_x, LB_R2);
  assign w_fb2 = w_fb1 ^ rotr(i_y, LB_R2);
  assign w_fc  = w_fa2 ^ rotr(w_fa2, LB_R3);
  assign w_fd  = w_fb2 ^ rotr(w_fb2, LB_R3);
  // The two halves cross-couple here: each output mixes in the other word's c/d term
  assign w_fa  = w_fa2 ^ rotr(w_fd, LB_R4) ^ rotr(w_fc, LB_R6);
  assign w_fb  = w_fb2 ^ rotr(w_fc, LB_R5) ^ rotr(w_fd, LB_R6);

  assign w_ia0 = i_x ^ rotr(i_x, LI_R0);
  assign w_ib0 = i_y ^ rotr(i_y, LI_R0);
  assign w_ic0 = i_x ^ rotr(w_ia0, LI_R1) ^ rotr(w_ia0, LI_R2);
  assign w_id0 = i_y ^ rotr(w_ib0, LI_R1) ^ rotr(w_ib0, LI_R2);
  assign w_ia1 = w_ic0 ^ rotr(w_ic0, LI_R1);
  assign w_ib1 = w_id0 ^ rotr(w_id0, LI_R1);
  assign w_ic1 = w_ic0 ^ rotr(w_ib1, LI_R3);
  assign w_id1 = w_id0 ^ rotr(w_ia1, LI_R0);
  assign w_ia2 = w_ia1 ^ rotr(w_ic1, LI_R4);
  assign w_ib2 = w_ib1 ^ rotr(w_id1, LI_R4);

  assign o_a = i_mode ? rotr(w_ia2, LI_R5) : w_fa;
  assign o_b = i_mode ? rotr(w_ib2, LI_R5) : w_fb;

endmodule

// File: rtl/lbox_layer_seq.sv
// Handshaked Clyde-128 L-box layer; LANES=2 transforms both pairs at once, LANES=1 reuses one core
// over two passes. Entry/exit byte bit-reversal is selectable with BYTE_REV.
module lbox_layer_seq
  import lbox_layer_seq_pkg::*;
#(
  parameter int LANES    = 2,
  parameter bit BYTE_REV = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_din_valid,
  output logic               o_din_ready,
  input  logic [STATE_W-1:0] i_din,
  input  logic               i_mode,
  output logic               o_dout_valid,
  input  logic               i_dout_ready,
  output logic [STATE_W-1:0] o_dout,
  output logic               o_busy
);

  fsm_e               r_fsm, w_fsm_nxt;
  logic               r_pass;
  logic [STATE_W-1:0] r_dout;
  logic               w_din_ready, w_accept, w_load_dout;
  logic [STATE_W-1:0] w_din_conv, w_result, w_dout_nxt;

  if (BYTE_REV) begin : g_conv
    assign w_din_conv = state_conv(i_din);
    assign w_dout_nxt = state_conv(w_result);
  end else begin : g_noconv
    assign w_din_conv = i_din;
    assign w_dout_nxt = w_result;
  end

  if (LANES == 2) begin : g_lanes2
    logic [WORD_W-1:0] w_a1, w_b1, w_a0, w_b0;

    lbox_layer_seq_core u_core_hi (
      .i_x(w_din_conv[127:96]), .i_y(w_din_conv[95:64]), .i_mode(i_mode),
      .o_a(w_a1), .o_b(w_b1)
    );
    lbox_layer_seq_core u_core_lo (
      .i_x(w_din_conv[63:32]), .i_y(w_din_conv[31:0]), .i_mode(i_mode),
      .o_a(w_a0), .o_b(w_b0)
    );

    assign w_result    = {w_a1, w_b1, w_a0, w_b0};
    assign w_load_dout = w_accept;
  end else if (LANES == 1) begin : g_lanes1
    logic [STATE_W-1:0] r_work;
    logic               r_mode;
    logic [WORD_W-1:0]  w_x, w_y, w_a, w_b;
    logic               w_cmode;

    // Pass 0 works straight off the input; pass 1 finishes the lower pair from the working register
    assign w_x     = r_pass ? r_work[63:32] : w_din_conv[127:96];
    assign w_y     = r_pass ? r_work[31:0]  : w_din_conv[95:64];
    assign w_cmode = r_pass ? r_mode        : i_mode;

    lbox_layer_seq_core u_core (
      .i_x(w_x), .i_y(w_y), .i_mode(w_cmode), .o_a(w_a), .o_b(w_b)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_work <= '0;
        r_mode <= 1'b0;
      end else if (w_accept) begin
        r_work <= {w_a, w_b, w_din_conv[63:0]};
        r_mode <= i_mode;
      end
    end

    assign w_result    = {r_work[127:64], w_a, w_b};
    assign w_load_dout = (r_fsm == RUN);
  end else begin : g_bad_lanes
    $error("lbox_layer_seq: LANES must be 1 or 2");
  end

  assign w_accept = i_din_valid & w_din_ready;

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_din_ready = 1'b0;
    case (r_fsm)
      IDLE: begin
        w_din_ready = 1'b1;
        if (i_din_valid) begin
          if (LANES == 2) w_fsm_nxt = DONE;
          else            w_fsm_nxt = RUN;
        end
      end
      RUN: begin
        if (r_pass == PASS_LAST) w_fsm_nxt = DONE;
      end
      DONE: begin
        if (i_dout_ready) begin
          w_din_ready = 1'b1;
          if (!i_din_valid)    w_fsm_nxt = IDLE;
          else if (LANES == 2) w_fsm_nxt = DONE;
          else                 w_fsm_nxt = RUN;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm  <= IDLE;
      r_pass <= 1'b0;
      r_dout <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (w_accept)          r_pass <= (LANES == 1);
      else if (r_fsm == RUN) r_pass <= 1'b0;
      if (w_load_dout)       r_dout <= w_dout_nxt;
    end
  end

  assign o_din_ready  = w_din_ready;
  assign o_dout_valid = (r_fsm == DONE);
  assign o_busy       = (r_fsm != IDLE);
  assign o_dout       = r_dout;

endmodule

// File: tb/tb_lbox_layer_seq.sv
// Directed bench for lbox_layer_seq: instance 0 is LANES=1/BYTE_REV=0, instance 1 is LANES=2/BYTE_REV=1.
module tb_lbox_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         din_valid [2];
  logic         din_ready [2];
  logic         mode      [2];
  logic         dout_valid[2];
  logic         dout_ready[2];
  logic         busy      [2];
  logic [127:0] din       [2];
  logic [127:0] dout      [2];

  int n_tests = 0;
  int n_fail  = 0;

  lbox_layer_seq #(.LANES(1), .BYTE_REV(1'b0)) u_dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_din_valid(din_valid[0]), .o_din_ready(din_ready[0]),
    .i_din(din[0]), .i_mode(mode[0]), .o_dout_valid(dout_valid[0]),
    .i_dout_ready(dout_ready[0]), .o_dout(dout[0]), .o_busy(busy[0])
  );

  lbox_layer_seq #(.LANES(2), .BYTE_REV(1'b1)) u_dut_l2 (
    .i_clk(clk), .i_rst(rst), .i_din_valid(din_valid[1]), .o_din_ready(din_ready[1]),
    .i_din(din[1]), .i_mode(mode[1]), .o_dout_valid(dout_valid[1]),
    .i_dout_ready(dout_ready[1]), .o_dout(dout[1]), .o_busy(busy[1])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model written from the published C description
  function automatic logic [31:0] m_rotr(input logic [31:0] v, input int n);
    logic [63:0] t;
    t = {v, v} >> n;
    return t[31:0];
  endfunction

  function automatic logic [63:0] m_lbox(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b, c, d;
    a = x ^ m_rotr(x, 12);  b = y ^ m_rotr(y, 12);
    a = a ^ m_rotr(a, 3);   b = b ^ m_rotr(b, 3);
    a = a ^ m_rotr(x, 17);  b = b ^ m_rotr(y, 17);
    c = a ^ m_rotr(a, 31);  d = b ^ m_rotr(b, 31);
    a = a ^ m_rotr(d, 26);  b = b ^ m_rotr(c, 25);
    a = a ^ m_rotr(c, 15);  b = b ^ m_rotr(d, 15);
    return {a, b};
  endfunction

  function automatic logic [63:0] m_lbox_inv(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b, c, d;
    a = x ^ m_rotr(x, 25);  b = y ^ m_rotr(y, 25);
    c = x ^ m_rotr(a, 31);  d = y ^ m_rotr(b, 31);
    c = c ^ m_rotr(a, 20);  d = d ^ m_rotr(b, 20);
    a = c ^ m_rotr(c, 31);  b = d ^ m_rotr(d, 31);
    c = c ^ m_rotr(b, 26);  d = d ^ m_rotr(a, 25);
    a = a ^ m_rotr(c, 17);  b = b ^ m_rotr(d, 17);
    return {m_rotr(a, 16), m_rotr(b, 16)};
  endfunction

  function automatic logic [127:0] m_brev(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 128; k++) r[k] = s[(k / 8) * 8 + 7 - (k % 8)];
    return r;
  endfunction

  function automatic logic [127:0] m_expect(input int s, input logic [127:0] d, input logic m);
    logic [127:0] t, r;
    t = (s == 1) ? m_brev(d) : d;
    if (m) r = {m_lbox_inv(t[127:96], t[95:64]), m_lbox_inv(t[63:32], t[31:0])};
    else   r = {m_lbox(t[127:96], t[95:64]), m_lbox(t[63:32], t[31:0])};
    return (s == 1) ? m_brev(r) : r;
  endfunction

  // One transaction with dout_ready high; mode is flipped right after accept to prove it is latched.
  task automatic send(input int s, input logic [127:0] d, input logic m,
                      output logic [127:0] res, output int lat);
    @(negedge clk);
    din[s] = d; mode[s] = m; din_valid[s] = 1'b1; dout_ready[s] = 1'b1;
    @(negedge clk);
    din_valid[s] = 1'b0; mode[s] = ~m;
    lat = 1;
    while (!dout_valid[s] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = dout[s];
  endtask

  task automatic backpressure(input int s, input logic [127:0] da, input logic [127:0] db);
    logic [127:0] held;
    int w;
    @(negedge clk);
    din[s] = da; mode[s] = 1'b0; din_valid[s] = 1'b1; dout_ready[s] = 1'b0;
    @(negedge clk);
    din[s] = db; mode[s] = 1'b1;
    w = 0;
    while (!dout_valid[s] && w < 10) begin
      @(negedge clk);
      w++;
    end
    held = dout[s];
    check("bp_first", held, m_expect(s, da, 1'b0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("bp_hold_dout", dout[s], held);
      check("bp_hold_flags", 128'({dout_valid[s], din_ready[s], busy[s]}), 128'(3'b101));
    end
    dout_ready[s] = 1'b1;
    #1;
    check("bp_release_ready", 128'(din_ready[s]), 128'(1'b1));
    @(negedge clk);
    din_valid[s] = 1'b0;
    check("bp_overlap_valid", 128'(dout_valid[s]), 128'(s == 1));
    w = 0;
    while (!dout_valid[s] && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("bp_second", dout[s], m_expect(s, db, 1'b1));
  endtask

  task automatic stream(input int s);
    logic [127:0] v[6];
    int i, cyc, nout, first, last;
    for (int k = 0; k < 6; k++) v[k] = {$urandom, $urandom, $urandom, $urandom};
    i = 0; cyc = 0; nout = 0; first = -1; last = -1;
    dout_ready[s] = 1'b1;
    @(negedge clk);
    din[s] = v[0]; mode[s] = 1'b0; din_valid[s] = 1'b1;
    while (nout < 6 && cyc < 40) begin
      #1;
      if (dout_valid[s]) begin
        check("stream_data", dout[s], m_expect(s, v[nout], 1'b0));
        if (first < 0) first = cyc;
        last = cyc;
        nout++;
      end
      if (din_ready[s] && din_valid[s]) i++;
      @(negedge clk);
      cyc++;
      if (i < 6) din[s] = v[i];
      else       din_valid[s] = 1'b0;
    end
    din_valid[s] = 1'b0;
    check("stream_count", 128'(nout), 128'(6));
    check("stream_spacing", 128'(last - first), 128'((s == 1) ? 5 : 10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, res2, d;
    logic m;
    int lat;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      din_valid[s] = 1'b0; din[s] = '0; mode[s] = 1'b0; dout_ready[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset_flags", 128'({dout_valid[s], busy[s], din_ready[s]}), 128'(3'b001));
      check("reset_dout", dout[s], 128'h0);
    end

    // Zero state in both modes, with latency
    for (int s = 0; s < 2; s++) begin
      for (int mm = 0; mm < 2; mm++) begin
        send(s, 128'h0, mm[0], res, lat);
        check("zero_dout", res, 128'h0);
        check("zero_latency", 128'(lat), 128'((s == 1) ? 1 : 2));
      end
    end

    // Hand-computed pair: LBox(1, 0) = (2014406E, 1BC001B0), and back again
    send(0, {32'h1, 96'h0}, 1'b0, res, lat);
    check("hand_fwd", res, {32'h2014406E, 32'h1BC001B0, 64'h0});
    send(0, {32'h2014406E, 32'h1BC001B0, 64'h0}, 1'b1, res, lat);
    check("hand_inv", res, {32'h1, 96'h0});
    send(0, {64'h0, 32'h1, 32'h0}, 1'b0, res, lat);
    check("hand_fwd_lo", res, {64'h0, 32'h2014406E, 32'h1BC001B0});

    // Random states against the model, then the opposite mode must restore the original
    for (int n = 0; n < 10; n++) begin
      for (int s = 0; s < 2; s++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        m = 1'($urandom_range(0, 1));
        send(s, d, m, res, lat);
        check("rand_model", res, m_expect(s, d, m));
        send(s, res, ~m, res2, lat);
        check("rand_roundtrip", res2, d);
      end
    end

    for (int s = 0; s < 2; s++)
      backpressure(s, {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom});

    for (int s = 0; s < 2; s++) stream(s);

    // Reset while the single-lane instance is mid-RUN on an inverse transaction
    @(negedge clk);
    d = {$urandom, $urandom, $urandom, $urandom};
    din[0] = d; mode[0] = 1'b1; din_valid[0] = 1'b1; dout_ready[0] = 1'b1;
    @(negedge clk);
    din_valid[0] = 1'b0;
    #1;
    check("pre_rst_run", 128'({dout_valid[0], busy[0]}), 128'(2'b01));
    rst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("midrst_flags", 128'({dout_valid[s], busy[s], din_ready[s]}), 128'(3'b001));
      check("midrst_dout", dout[s], 128'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(0, d, 1'b1, res, lat);
    check("post_rst_data", res, m_expect(0, d, 1'b1));
    check("post_rst_latency", 128'(lat), 128'(2));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
